// File: rtl/fifo_ctrl.sv
// FIFO pointer/status controller: write enable, head/tail addresses, level and sticky error flags.
// Latency: status updates one edge after the request. Backpressure: a push is rejected when full unless it pops in the same cycle; a pop is rejected when empty.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_TH      = 6,
   parameter int AE_TH      = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int LW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ovf_set;
   logic                  udf_set;

   // A push into a full FIFO is allowed when a pop frees the head slot in the same cycle.
   assign push_ok = wr & (~full | rd);
   assign pop_ok  = rd & ~empty;
   assign ovf_set = wr & ~push_ok;
   assign udf_set = rd & ~pop_ok;

   assign wr_en  = push_ok;
   assign w_addr = w_ptr;
   assign r_addr = r_ptr;

   assign full         = (level == LW'(DEPTH));
   assign empty        = (level == '0);
   assign almost_full  = (level >= LW'(AF_TH));
   assign almost_empty = (level <= LW'(AE_TH));

   // reset_n is active-high here: the existing codebase named it before its polarity was fixed.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
         if (pop_ok)  r_ptr <= r_ptr + ADDR_WIDTH'(1);
         level     <= level + LW'(push_ok) - LW'(pop_ok);
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= udf_set | (underflow & ~clr_err);
      end
   end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed bench for fifo_ctrl against a queue-based FIFO model with a local storage array.
module tb_fifo_ctrl;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr, rd, clr_err;
   logic          wr_en;
   logic [AW-1:0] w_addr, r_addr;
   logic          full, empty, almost_full, almost_empty;
   logic [AW:0]   level;
   logic          overflow, underflow;
   logic [7:0]    wdat;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    r_data;

   int checks = 0;
   int failures = 0;

   // model state
   logic [7:0] q[$];
   int         pushes, pops;
   bit         ov_m, un_m;

   fifo_ctrl #(.ADDR_WIDTH(AW), .AF_TH(6), .AE_TH(1)) dut (
      .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .clr_err(clr_err),
      .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) if (wr_en) mem[w_addr] <= wdat;
   assign r_data = mem[r_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pushes = 0;
      pops   = 0;
      ov_m   = 1'b0;
      un_m   = 1'b0;
   endtask

   task automatic check_status();
      int n;
      n = q.size();
      chk("level", 32'(level), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
      chk("w_addr", 32'(w_addr), 32'(pushes % DEPTH));
      chk("r_addr", 32'(r_addr), 32'(pops % DEPTH));
      chk("overflow", 32'(overflow), 32'(ov_m));
      chk("underflow", 32'(underflow), 32'(un_m));
   endtask

   // Called just after a rising edge; drives one cycle of requests and checks mid-cycle.
   task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
      bit push_ok, pop_ok;
      wr = w; rd = r; clr_err = c; wdat = d;
      #4;
      push_ok = w && (q.size() < DEPTH || r);
      pop_ok  = r && (q.size() != 0);
      check_status();
      chk("wr_en", 32'(wr_en), 32'(push_ok));
      if (pop_ok) chk("r_data", 32'(r_data), 32'(q[0]));
      @(posedge clk);
      if (pop_ok) begin void'(q.pop_front()); pops++; end
      if (push_ok) begin q.push_back(d); pushes++; end
      ov_m = (w && !push_ok) ? 1'b1 : (c ? 1'b0 : ov_m);
      un_m = (r && !pop_ok)  ? 1'b1 : (c ? 1'b0 : un_m);
      #1;
   endtask

   // Asynchronous reset pulse between edges; outputs must reach reset values before the next edge.
   task automatic async_reset();
      #1 reset_n = 1'b1;
      #1;
      model_reset();
      check_status();
      wr = 1'b0; rd = 1'b0;
      #0.1 chk("wr_en_rst", 32'(wr_en), 32'd0);
      reset_n = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; wdat = 8'h00;
      model_reset();
      #2;
      check_status();
      chk("wr_en_reset", 32'(wr_en), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b0;

      // fill, overflow, clear
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'hF0 + 8'(i));
      cycle(1'b1, 1'b0, 1'b0, 8'hAA);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      // drain and underflow
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      // wrap
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      // fill to full, then simultaneous push/pop while full
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'h40 + 8'(i));
      // drain, then simultaneous push/pop while empty
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h55);
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      // level 4 then asynchronous reset
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      async_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h77);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 600; i++) begin
         logic w, r, c;
         int bias;
         bias = (i / 100) % 3;
         w = ($urandom_range(0, 99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
         r = ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
         c = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) async_reset();
         cycle(w, r, c, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller that drives the write and read ports of the FIFO's register-file storage. Turns push/pop requests into storage write enable and addresses, and tracks occupancy, full/empty, almost-full/almost-empty and sticky overflow/underflow errors. It sits between the FIFO user interface and the storage array: it produces `wr_en`, `w_addr` and `r_addr`, and the storage returns the head word asynchronously on `r_data` (first-word fall-through).

## Interface
- `ADDR_WIDTH`, default 3: storage address width. Depth is `DEPTH = 2**ADDR_WIDTH`.
- `AF_TH`, default 6: `almost_full` asserts when `level >= AF_TH`. Legal range 1..DEPTH.
- `AE_TH`, default 1: `almost_empty` asserts when `level <= AE_TH`. Legal range 0..DEPTH-1.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset_n`, in, 1: reset, asynchronous, active-high (`reset_n = 1` resets).
- `wr`, in, 1: push request for this cycle.
- `rd`, in, 1: pop request for this cycle; the head word is on storage `r_data` during the cycle.
- `clr_err`, in, 1: synchronous clear of the `overflow` and `underflow` flags.
- `wr_en`, out, 1: storage write enable, combinational.
- `w_addr`, out, ADDR_WIDTH: storage write address (tail).
- `r_addr`, out, ADDR_WIDTH: storage read address (head).
- `full`, out, 1: `level == DEPTH`.
- `empty`, out, 1: `level == 0`.
- `almost_full`, out, 1: see `AF_TH`.
- `almost_empty`, out, 1: see `AE_TH`.
- `level`, out, ADDR_WIDTH+1: number of stored words, 0..DEPTH.
- `overflow`, out, 1: sticky; set by a rejected push.
- `underflow`, out, 1: sticky; set by a rejected pop.

## Operation
- State: `w_ptr`, `r_ptr` (ADDR_WIDTH bits each, wrap modulo DEPTH), `level` (ADDR_WIDTH+1 bits).
- Accept rules, evaluated on registered flags:
  - `push_ok = wr & (~full | rd)`
  - `pop_ok = rd & ~empty`
- `wr_en = push_ok`.
- `w_addr = w_ptr`.
- `r_addr = r_ptr`.
- On each clock edge:
  - if `push_ok`, `w_ptr` increments.
  - if `pop_ok`, `r_ptr` increments.
  - `level` increments by `push_ok - pop_ok`.
- Case table for (`wr`, `rd`):
  - 00: hold.
  - 10: push if not full, else reject and set `overflow`.
  - 01: pop if not empty, else reject and set `underflow`.
  - 11 when neither full nor empty: push and pop; `level` unchanged.
  - 11 when full: pop and push both accepted. The storage write lands at the freed slot (`w_ptr == r_ptr`); the read sees the old word because the write commits at the edge. `level` stays DEPTH. No overflow.
  - 11 when empty: push accepted, pop rejected, `underflow` set, `level` becomes 1.
- Flags are derived combinationally from registered `level`, so they have no extra lag beyond `level`.
- `overflow`/`underflow`:
  - set on the edge where the rejection occurs.
  - cleared by `clr_err` on the next edge.
  - if a set condition and `clr_err` occur in the same cycle, set wins.
- Pointers wrap from DEPTH-1 to 0 with no special handling.
- Full/empty are distinguished by `level`, not by pointer equality.

## Timing
- Reset values, applied immediately on `reset_n = 1` regardless of `clk`:
  - `w_ptr = r_ptr = 0`, so `w_addr = r_addr = 0`.
  - `level = 0`, `empty = 1`, `full = 0`.
  - `almost_empty = 1` (since 0 <= AE_TH), `almost_full = 0`.
  - `overflow = underflow = 0`.
  - `wr_en = 0` while `wr = 0`.
- Reset asserted mid-operation discards all contents and returns to the reset values. Storage contents are not cleared. The first edge after `reset_n` returns to 0 behaves normally.
- Write latency: a word pushed at edge N is visible on `r_data` (as head, if the FIFO was empty) after edge N. `empty` deasserts after edge N, so the earliest pop of that word is the cycle following edge N.
- Status outputs and `level` change only at clock edges, except on asynchronous reset.
- `wr_en` is combinational from `wr`, `rd`, `full` within the cycle.

## Test plan
- Reset, then push 0xF0..0xF7 on consecutive cycles (DEPTH 8):
  - `w_addr` steps 0..7; `level` goes 1..8.
  - `almost_full` sets after the 6th push; `full` sets after the 8th; `overflow = 0`.
- Ninth push while full (`rd = 0`):
  - `wr_en = 0`; `w_ptr` stays 0; `level` stays 8; `overflow = 1`.
  - `clr_err` pulse clears it on the next edge.
- Pop 8 times:
  - `r_addr` steps 0..7; storage `r_data` reads 0xF0..0xF7.
  - `level` goes 8..0; `almost_empty` sets at level 1; `empty` sets at level 0.
  - A 9th pop sets `underflow` and leaves `r_ptr = 0`.
- Wrap: push 5, pop 5, then push 6.
  - `w_addr` sequence is 5,6,7,0,1,2; `level = 6`; data order preserved on read.
- Simultaneous `wr = rd = 1`:
  - When full: `level` stays 8, both pointers advance, no overflow.
  - When empty: `level` becomes 1, `underflow` sets, `r_ptr` unchanged.
- Assert `reset_n` asynchronously between edges with `level = 4`:
  - All outputs go to reset values before the next edge.
  - A subsequent push writes `w_addr = 0`.
